// File: rtl/fetch_sequencer_if.sv
// Instruction-side bus bundle: instruction-memory req/ack, decode valid/ready,
// and the execute-resolution feedback consumed by the sequencer.
interface fetch_sequencer_if #(
    parameter int ADDR_W = 32
) ();
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [31:0]       imem_rdata;
    logic [31:0]       instr;
    logic              instr_valid;
    logic              instr_ready;
    logic              exec_done;
    logic [2:0]        branch;
    logic              flag_n;
    logic              flag_z;
    logic              halt;

    modport master (
        output imem_req, imem_addr, instr, instr_valid,
        input  imem_ack, imem_rdata, instr_ready, exec_done, branch, flag_n, flag_z, halt
    );

    modport slave (
        input  imem_req, imem_addr, instr, instr_valid,
        output imem_ack, imem_rdata, instr_ready, exec_done, branch, flag_n, flag_z, halt
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Non-pipelined fetch sequencer: owns the PC, fetches one word at a time,
// issues it to decode and resolves the next PC from the execute feedback.
module fetch_sequencer #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    fetch_sequencer_if.master bus,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        ISSUE  = 2'd1,
        EXEC   = 2'd2,
        HALTED = 2'd3
    } state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic              req_q;
    logic [31:0]       instr_q;
    logic              valid_q;
    logic              halted_q;

    logic              taken;
    logic [ADDR_W-1:0] seq_pc;
    logic [ADDR_W-1:0] offset;

    always_comb begin
        taken = 1'b0;
        case (bus.branch)
            3'b001:  taken = 1'b1;
            3'b010:  taken = bus.flag_n;
            3'b011:  taken = ~bus.flag_n;
            3'b100:  taken = bus.flag_z;
            default: taken = 1'b0;
        endcase
        seq_pc = pc_q + ADDR_W'(1);
        offset = ADDR_W'($signed(instr_q[15:0]));
        pc_d   = taken ? (seq_pc + offset) : seq_pc;
    end

    // req_q stays low for the first cycle out of reset, so the request rises
    // on the first edge after rst_n deasserts; ack is only honoured with req high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FETCH;
            pc_q     <= RESET_PC;
            req_q    <= 1'b0;
            instr_q  <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            unique case (state_q)
                FETCH: begin
                    if (req_q && bus.imem_ack) begin
                        instr_q <= bus.imem_rdata;
                        req_q   <= 1'b0;
                        valid_q <= 1'b1;
                        state_q <= ISSUE;
                    end else begin
                        req_q <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (bus.instr_ready) begin
                        valid_q <= 1'b0;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    if (bus.exec_done) begin
                        if (bus.halt) begin
                            halted_q <= 1'b1;
                            state_q  <= HALTED;
                        end else begin
                            pc_q    <= pc_d;
                            req_q   <= 1'b1;
                            state_q <= FETCH;
                        end
                    end
                end
                HALTED: begin
                end
            endcase
        end
    end

    assign bus.imem_req    = req_q;
    assign bus.imem_addr   = pc_q;
    assign bus.instr       = instr_q;
    assign bus.instr_valid = valid_q;
    assign pc              = pc_q;
    assign halted          = halted_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: instruction table with hand-computed
// next-PC values plus hand sequences for halt and asynchronous reset.
module tb_fetch_sequencer;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc;
    logic        halted;

    int total;
    int bad;

    fetch_sequencer_if #(.ADDR_W(32)) bus ();

    fetch_sequencer #(
        .ADDR_W  (32),
        .RESET_PC(32'h10)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .pc    (pc),
        .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
        logic [2:0]  br;
        logic        fn;
        logic        fz;
        logic        hlt;
        int          ack_dly;
        int          rdy_dly;
        logic [31:0] nxt;
    } vec_t;

    vec_t vq[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.imem_ack    = 1'b0;
        bus.imem_rdata  = 32'hDEAD_BEEF;
        bus.instr_ready = 1'b0;
        bus.exec_done   = 1'b0;
        bus.branch      = 3'b000;
        bus.flag_n      = 1'b0;
        bus.flag_z      = 1'b0;
        bus.halt        = 1'b0;
    endtask

    task automatic run_instr(input vec_t v);
        check("fetch_addr", bus.imem_addr, v.pc);
        check("fetch_pc", pc, v.pc);
        check("fetch_req", bus.imem_req, 1'b1);
        // stray exec_done/ready while fetching must be ignored
        for (int i = 0; i < v.ack_dly; i++) begin
            bus.exec_done   = 1'b1;
            bus.branch      = 3'b001;
            bus.instr_ready = 1'b1;
            step();
            check("req_hold", bus.imem_req, 1'b1);
            check("valid_in_fetch", bus.instr_valid, 1'b0);
        end
        idle_inputs();
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = v.word;
        step();
        idle_inputs();
        check("issue_valid", bus.instr_valid, 1'b1);
        check("issue_instr", bus.instr, v.word);
        check("req_drop", bus.imem_req, 1'b0);
        for (int i = 0; i < v.rdy_dly; i++) begin
            bus.exec_done = 1'b1;
            bus.branch    = 3'b001;
            bus.halt      = 1'b1;
            bus.imem_ack  = 1'b1;
            step();
            check("valid_hold", bus.instr_valid, 1'b1);
            check("instr_stable", bus.instr, v.word);
        end
        idle_inputs();
        bus.instr_ready = 1'b1;
        step();
        idle_inputs();
        check("valid_pulse_end", bus.instr_valid, 1'b0);
        check("exec_req", bus.imem_req, 1'b0);
        bus.exec_done = 1'b1;
        bus.branch    = v.br;
        bus.flag_n    = v.fn;
        bus.flag_z    = v.fz;
        bus.halt      = v.hlt;
        step();
        idle_inputs();
        if (v.hlt) begin
            check("halted_set", halted, 1'b1);
            check("halt_req", bus.imem_req, 1'b0);
            check("halt_pc", pc, v.pc);
        end else begin
            check("next_req", bus.imem_req, 1'b1);
            check("next_addr", bus.imem_addr, v.nxt);
            check("not_halted", halted, 1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        idle_inputs();

        //        pc            word          br    fn    fz    hlt   ack rdy nxt
        vq.push_back('{32'h10,       32'h0000_0000, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0, 32'h11});
        vq.push_back('{32'h11,       32'h0000_0000, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0, 32'h12});
        vq.push_back('{32'h12,       32'h6000_000D, 3'b001, 1'b0, 1'b0, 1'b0, 0, 0, 32'h20});
        vq.push_back('{32'h20,       32'h6000_0005, 3'b001, 1'b0, 1'b0, 1'b0, 0, 0, 32'h26});
        vq.push_back('{32'h26,       32'h6000_FFF9, 3'b001, 1'b0, 1'b0, 1'b0, 0, 0, 32'h20});
        vq.push_back('{32'h20,       32'h6000_FFFE, 3'b001, 1'b0, 1'b0, 1'b0, 0, 0, 32'h1F});
        vq.push_back('{32'h1F,       32'h6000_0010, 3'b001, 1'b0, 1'b0, 1'b0, 0, 0, 32'h30});
        vq.push_back('{32'h30,       32'h0000_0004, 3'b010, 1'b0, 1'b1, 1'b0, 0, 0, 32'h31});
        vq.push_back('{32'h31,       32'h6000_FFFE, 3'b001, 1'b0, 1'b0, 1'b0, 0, 0, 32'h30});
        vq.push_back('{32'h30,       32'h0000_0004, 3'b100, 1'b0, 1'b1, 1'b0, 0, 0, 32'h35});
        vq.push_back('{32'h35,       32'h6000_FFFA, 3'b001, 1'b0, 1'b0, 1'b0, 0, 0, 32'h30});
        vq.push_back('{32'h30,       32'h0000_0004, 3'b011, 1'b1, 1'b1, 1'b0, 0, 0, 32'h31});
        vq.push_back('{32'h31,       32'h6000_FFFE, 3'b001, 1'b0, 1'b0, 1'b0, 0, 0, 32'h30});
        vq.push_back('{32'h30,       32'h0000_0004, 3'b111, 1'b1, 1'b1, 1'b0, 0, 0, 32'h31});
        vq.push_back('{32'h31,       32'h0000_0002, 3'b010, 1'b1, 1'b0, 1'b0, 0, 0, 32'h34});
        vq.push_back('{32'h34,       32'h0000_FFFF, 3'b011, 1'b0, 1'b0, 1'b0, 0, 0, 32'h34});
        vq.push_back('{32'h34,       32'h0000_0004, 3'b100, 1'b1, 1'b0, 1'b0, 0, 0, 32'h35});
        vq.push_back('{32'h35,       32'h0000_0004, 3'b101, 1'b1, 1'b1, 1'b0, 0, 0, 32'h36});
        vq.push_back('{32'h36,       32'h1234_5678, 3'b000, 1'b0, 1'b0, 1'b0, 5, 3, 32'h37});
        vq.push_back('{32'h37,       32'h6000_FFC7, 3'b001, 1'b0, 1'b0, 1'b0, 0, 0, 32'hFFFF_FFFF});
        vq.push_back('{32'hFFFF_FFFF, 32'h0000_0000, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0, 32'h0});
        vq.push_back('{32'h0,        32'h6000_003F, 3'b001, 1'b0, 1'b0, 1'b0, 0, 0, 32'h40});
        vq.push_back('{32'h40,       32'h6000_0004, 3'b001, 1'b0, 1'b0, 1'b1, 0, 0, 32'h40});

        step();
        step();
        check("rst_pc", pc, 32'h10);
        check("rst_addr", bus.imem_addr, 32'h10);
        check("rst_req", bus.imem_req, 1'b0);
        check("rst_instr", bus.instr, 32'h0);
        check("rst_valid", bus.instr_valid, 1'b0);
        check("rst_halted", halted, 1'b0);

        rst_n = 1'b1;
        check("req_low_before_edge", bus.imem_req, 1'b0);
        step();

        for (int k = 0; k < vq.size(); k++) begin
            run_instr(vq[k]);
        end

        // halted: every input ignored for 20 cycles
        for (int i = 0; i < 20; i++) begin
            bus.imem_ack    = 1'b1;
            bus.instr_ready = 1'b1;
            bus.exec_done   = 1'b1;
            bus.branch      = 3'b001;
            step();
            check("hlt_halted", halted, 1'b1);
            check("hlt_req", bus.imem_req, 1'b0);
            check("hlt_valid", bus.instr_valid, 1'b0);
            check("hlt_pc", pc, 32'h40);
        end
        idle_inputs();

        #2;
        rst_n = 1'b0;
        #1;
        check("hrst_pc", pc, 32'h10);
        check("hrst_halted", halted, 1'b0);
        step();
        rst_n = 1'b1;
        step();
        check("resume_req", bus.imem_req, 1'b1);
        check("resume_addr", bus.imem_addr, 32'h10);

        // reset while an instruction sits unaccepted in ISSUE
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hA5A5_A5A5;
        step();
        idle_inputs();
        check("pre_rst_valid", bus.instr_valid, 1'b1);
        check("pre_rst_instr", bus.instr, 32'hA5A5_A5A5);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", bus.instr_valid, 1'b0);
        check("arst_instr", bus.instr, 32'h0);
        check("arst_req", bus.imem_req, 1'b0);
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_req", bus.imem_req, 1'b1);
        check("post_rst_valid", bus.instr_valid, 1'b0);

        // reset with a memory request outstanding
        #2;
        rst_n = 1'b0;
        #1;
        check("fetch_rst_req", bus.imem_req, 1'b0);
        step();
        rst_n = 1'b1;
        step();
        check("fetch_rst_resume", bus.imem_req, 1'b1);
        check("fetch_rst_addr", bus.imem_addr, 32'h10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
